triple_sampler: RTL and testbench
=================================

// Module: triple_sampler
// PURPOSE
//   Front-end stage for the 3-bit majority voter: samples a serial line din once per
//   sample tick, packs three consecutive samples into A[2:0], and hands the triple
//   downstream with a valid/ready handshake. A prescaler sets the tick rate. A saturating
//   counter records triples dropped because the consumer was not ready.
// PARAMETERS
//   DIV    4  clock cycles per sample tick (>=1); DIV=1 -> tick every enabled cycle
//   CNT_W  8  width of the overflow counter ovf_cnt
// PORTS
//   clk      in   1      system clock, all state updates on rising edge
//   reset    in   1      asynchronous, active-high reset
//   en       in   1      sampling enable; 0 = prescaler and partial triple cleared
//   din      in   1      serial input line, sampled only on a tick
//   a_ready  in   1      downstream accepts A this cycle
//   A        out  3      completed triple; A[2]=oldest sample, A[0]=newest
//   a_valid  out  1      A holds an unconsumed triple
//   busy     out  1      1 while 1 or 2 samples of a triple have been collected
//   ovf_cnt  out  CNT_W  count of dropped triples, saturating at all-ones
// BEHAVIOUR
//   - Reset (async, immediate): A=0, a_valid=0, busy=0, ovf_cnt=0, prescaler=0, n=0, sh=0.
//   - Prescaler pc: en=1 -> pc counts 0..DIV-1 and wraps; tick=1 when en=1 && pc==DIV-1.
//     en=0 -> pc<=0, no tick. First tick comes DIV edges after en rises.
//   - Sample index n (0..2), shift reg sh[1:0]: on tick with n<2: sh<={sh[0],din}, n<=n+1.
//     On tick with n==2: triple T={sh[1],sh[0],din} is complete, n<=0.
//   - busy = (n!=0), registered-state derived, no combinational path from din.
//   - Output slot free this cycle iff a_valid==0 || a_ready==1.
//   - Triple complete && slot free: A<=T, a_valid<=1 (simultaneous accept+load = no gap, no loss).
//   - Triple complete && slot not free: T discarded, A/a_valid unchanged,
//     ovf_cnt<=ovf_cnt+1 unless already all-ones (saturate, no wrap).
//   - Accept (a_valid && a_ready) without new triple: a_valid<=0 next edge; A retains value.
//   - A is stable while a_valid=1 and not accepted.
//   - en falling mid-triple: n<=0, sh<=0, pc<=0 on that edge; partial samples lost, not
//     counted as overflow. A, a_valid, ovf_cnt unaffected; handshake continues with en=0.
//   - Reset mid-operation: as reset above; pending triple and counter lost.
//   - Latency: completing tick edge -> a_valid high after that same edge (1 register stage).
//   - States (implicit in n): IDLE(en=0) / S0 / S1 / S2 -> S0 on completion.
// TESTING
//   1. DIV=4, en=1 from cycle 0, din=1,0,1 at ticks, a_ready=1 -> ticks at edges 4,8,12;
//      A=3'b101, a_valid=1 for exactly 1 cycle after edge 12; busy=1 after edges 4 and 8.
//   2. a_ready=0, two triples 110 then 011 -> A stays 3'b110, a_valid held, ovf_cnt=1;
//      then a_ready=1 one cycle -> a_valid=0 next edge.
//   3. en dropped after 2 samples (1,1), re-raised, din=0,0,1 -> A=3'b001, ovf_cnt=0.
//   4. reset pulsed mid-triple with a_valid=1 -> A=0, a_valid=0, busy=0, ovf_cnt=0
//      immediately, before next clk edge.
//   5. CNT_W=2, a_ready=0, 5 triples completed after first -> ovf_cnt saturates at 2'b11.
//   6. DIV=1, a_ready=1 constantly, din pattern 111000 repeating -> A=111,000 alternating
//      every 3 cycles, a_valid pulses 1 cycle each, ovf_cnt=0.

Source files
------------

// File: rtl/triple_sampler.sv
// Serial front-end for the 3-bit majority voter: samples din on prescaled ticks,
// packs three samples into A and offers them downstream over a valid/ready handshake.
module triple_sampler #(
    parameter int DIV   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             a_ready,
    output logic [2:0]       A,
    output logic             a_valid,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int              PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);
    localparam logic [CNT_W-1:0] OVF_MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       n_q, n_d;
    logic [1:0]       sh_q, sh_d;
    logic [2:0]       a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic             tick_s;
    logic             complete_s;
    logic             slot_free_s;
    logic [2:0]       triple_s;

    // Prescaler, sample collection and tick generation.
    always_comb begin
        pc_d       = pc_q;
        n_d        = n_q;
        sh_d       = sh_q;
        tick_s     = 1'b0;
        complete_s = 1'b0;
        triple_s   = {sh_q, din};
        if (!en) begin
            pc_d = {PC_W{1'b0}};
            n_d  = 2'd0;
            sh_d = 2'b00;
        end else begin
            tick_s = (pc_q == PC_LAST);
            if (tick_s) begin
                pc_d = {PC_W{1'b0}};
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
            if (tick_s) begin
                case (n_q)
                    2'd0, 2'd1: begin
                        sh_d = {sh_q[0], din};
                        n_d  = n_q + 2'd1;
                    end
                    2'd2: begin
                        complete_s = 1'b1;
                        n_d        = 2'd0;
                        sh_d       = 2'b00;
                    end
                    default: begin
                        n_d  = 2'd0;
                        sh_d = 2'b00;
                    end
                endcase
            end else begin
                n_d  = n_q;
                sh_d = sh_q;
            end
        end
        busy_d = (n_d != 2'd0);
    end

    // Output slot handshake and saturating drop counter.
    always_comb begin
        a_d         = a_q;
        a_valid_d   = a_valid_q;
        ovf_d       = ovf_q;
        slot_free_s = !a_valid_q || a_ready;
        if (complete_s) begin
            if (slot_free_s) begin
                a_d       = triple_s;
                a_valid_d = 1'b1;
            end else if (ovf_q != OVF_MAX) begin
                ovf_d = ovf_q + CNT_W'(1);
            end else begin
                ovf_d = ovf_q;
            end
        end else if (a_valid_q && a_ready) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= {PC_W{1'b0}};
            n_q       <= 2'd0;
            sh_q      <= 2'b00;
            a_q       <= 3'b000;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= {CNT_W{1'b0}};
        end else begin
            pc_q      <= pc_d;
            n_q       <= n_d;
            sh_q      <= sh_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign A       = a_q;
    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_triple_sampler.sv
// Randomized and directed bench for triple_sampler; two instances (DIV=4/CNT_W=8 and
// DIV=1/CNT_W=2) share stimulus and are checked against a cycle-counting sample model.
module tb_triple_sampler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       a_ready = 1'b0;
    logic [2:0] a0, a1;
    logic       v0, v1, b0, b1;
    logic [7:0] o0;
    logic [1:0] o1;

    int tests = 0;
    int fails = 0;

    // Model state per instance: 0 = DIV 4 / CNT_W 8, 1 = DIV 1 / CNT_W 2
    int m_div [2] = '{4, 1};
    int m_max [2] = '{255, 3};
    int m_cyc [2];
    int m_cnt [2];
    int m_val [2];
    int m_a   [2];
    int m_v   [2];
    int m_ovf [2];

    always #5 clk = ~clk;

    triple_sampler #(.DIV(4), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .en(en), .din(din), .a_ready(a_ready),
        .A(a0), .a_valid(v0), .busy(b0), .ovf_cnt(o0)
    );

    triple_sampler #(.DIV(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .en(en), .din(din), .a_ready(a_ready),
        .A(a1), .a_valid(v1), .busy(b1), .ovf_cnt(o1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_cnt[i] = 0; m_val[i] = 0;
            m_a[i] = 0; m_v[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit done = 1'b0;
            int trip = 0;
            bit free = (m_v[i] == 0) || a_ready;
            if (en) begin
                m_cyc[i]++;
                if (m_cyc[i] % m_div[i] == 0) begin
                    m_val[i] = m_val[i] * 2 + int'(din);
                    m_cnt[i]++;
                    if (m_cnt[i] == 3) begin
                        done = 1'b1;
                        trip = m_val[i];
                        m_cnt[i] = 0;
                        m_val[i] = 0;
                    end
                end
            end else begin
                m_cyc[i] = 0; m_cnt[i] = 0; m_val[i] = 0;
            end
            if (done) begin
                if (free) begin
                    m_a[i] = trip;
                    m_v[i] = 1;
                end else if (m_ovf[i] < m_max[i]) begin
                    m_ovf[i]++;
                end
            end else if (m_v[i] == 1 && a_ready) begin
                m_v[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("A0",     32'(a0), 32'(m_a[0]));
        chk("valid0", 32'(v0), 32'(m_v[0]));
        chk("busy0",  32'(b0), 32'(m_cnt[0] != 0));
        chk("ovf0",   32'(o0), 32'(m_ovf[0]));
        chk("A1",     32'(a1), 32'(m_a[1]));
        chk("valid1", 32'(v1), 32'(m_v[1]));
        chk("busy1",  32'(b1), 32'(m_cnt[1] != 0));
        chk("ovf1",   32'(o1), 32'(m_ovf[1]));
    endtask

    task automatic step(input logic e, input logic d, input logic r);
        en = e; din = d; a_ready = r;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Ticks for DIV=4 at edges 4, 8, 12 sampling 1, 0, 1
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, (k <= 4 || k > 8) ? 1'b1 : 1'b0, 1'b1);
            if (k == 4 || k == 8) chk("busy_dir", 32'(b0), 32'd1);
        end
        chk("A_101", 32'(a0), 32'd5);
        chk("valid_101", 32'(v0), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("valid_pulse", 32'(v0), 32'd0);

        // Consumer stalled: overflows accumulate, dut1 saturates
        for (int k = 0; k < 40; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        chk("ovf1_sat", 32'(o1), 32'd3);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Enable dropped mid-triple, then resumed
        for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 1'b1);
        chk("busy_mid", 32'(b0), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("busy_drop", 32'(b0), 32'd0);
        for (int k = 1; k <= 12; k++) step(1'b1, (k > 8) ? 1'b1 : 1'b0, 1'b1);
        chk("A_001", 32'(a0), 32'd1);

        // Reset with a triple pending
        for (int k = 0; k < 14; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        pulse_reset();

        // DIV=1 repeating 111000
        for (int k = 0; k < 24; k++) step(1'b1, (k % 6 < 3) ? 1'b1 : 1'b0, 1'b1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0));
            if (k == 300) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
